// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle subtract/add over WIDTH bits, BITS_PER_CYCLE bits per clock,
// least-significant slice first, with a start/busy/done handshake.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears state and all outputs, aborts a run)
//   start  request; sampled only while idle
//   mode   0 = a - b - bin, 1 = a + b + bin (latched with start)
//   a, b   operands (latched with start)
//   bin    borrow-in / carry-in (latched with start)
//   busy   operation in progress
//   done   one-cycle completion pulse
//   diff   result, updated only at completion
//   bout   borrow-out (sub) / carry-out (add), updated only at completion
//   zero   diff == 0, updated only at completion
module serial_subtractor #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $fatal(1, "serial_subtractor: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
  end

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    res_q;
  logic                mode_q;
  logic                cy_q;
  logic [CntW-1:0]     cnt_q;

  logic [BITS_PER_CYCLE-1:0] slice;
  logic                      cy_next;
  logic                      cy_tmp;
  logic [WIDTH-1:0]          res_next;

  // Operands are shifted right each RUN cycle, so the current slice always sits in the low bits.
  // The result buffer fills from the top, so after N slices it holds the full result in place.
  always_comb begin
    cy_tmp = cy_q;
    slice  = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice[i] = a_q[i] ^ b_q[i] ^ cy_tmp;
      if (mode_q) begin
        cy_tmp = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & cy_tmp);
      end else begin
        cy_tmp = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & cy_tmp);
      end
    end
    cy_next  = cy_tmp;
    res_next = (res_q >> BITS_PER_CYCLE) | (WIDTH'(slice) << (WIDTH - BITS_PER_CYCLE));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            cy_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q   <= a_q >> BITS_PER_CYCLE;
          b_q   <= b_q >> BITS_PER_CYCLE;
          cy_q  <= cy_next;
          res_q <= res_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            diff    <= res_next;
            bout    <= cy_next;
            zero    <= (res_next == '0);
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (W8/BPC1, W8/BPC4, W8/BPC8, W3/BPC1) share
// operand inputs and reset, each with its own start. Expected results are queued when a start
// is driven and compared, with their due cycle, when the instance pulses done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       mode;
  logic       bin;
  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] start_v;
  logic [3:0] busy_v;
  logic [3:0] done_v;
  logic [3:0] bout_v;
  logic [3:0] zero_v;
  logic [7:0] d0, d1, d2;
  logic [2:0] d3;
  logic [7:0] diff_v [4];

  assign diff_v[0] = d0;
  assign diff_v[1] = d1;
  assign diff_v[2] = d2;
  assign diff_v[3] = {5'b0, d3};

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_w8b1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .a(a), .b(b), .bin(bin),
    .busy(busy_v[0]), .done(done_v[0]), .diff(d0), .bout(bout_v[0]), .zero(zero_v[0])
  );
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_w8b4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .a(a), .b(b), .bin(bin),
    .busy(busy_v[1]), .done(done_v[1]), .diff(d1), .bout(bout_v[1]), .zero(zero_v[1])
  );
  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(8)) u_w8b8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .mode(mode), .a(a), .b(b), .bin(bin),
    .busy(busy_v[2]), .done(done_v[2]), .diff(d2), .bout(bout_v[2]), .zero(zero_v[2])
  );
  serial_subtractor #(.WIDTH(3), .BITS_PER_CYCLE(1)) u_w3b1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .mode(mode), .a(a[2:0]), .b(b[2:0]),
    .bin(bin), .busy(busy_v[3]), .done(done_v[3]), .diff(d3), .bout(bout_v[3]),
    .zero(zero_v[3])
  );

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    int         due;
  } exp_t;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
    logic [7:0] d;
    logic       bo;
    logic       z;
  } vec_t;

  exp_t       sb [4][$];
  logic [7:0] last_diff [4];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    case (k)
      0:       return 8;
      1:       return 2;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      if (done_v[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          check($sformatf("u%0d unexpected_done", k), 32'd1, 32'd0);
        end else begin
          e = sb[k].pop_front();
          check($sformatf("u%0d diff", k), 32'(diff_v[k]), 32'(e.diff));
          check($sformatf("u%0d bout", k), 32'(bout_v[k]), 32'(e.bout));
          check($sformatf("u%0d zero", k), 32'(zero_v[k]), 32'(e.zero));
          check($sformatf("u%0d done_cycle", k), 32'(cyc), 32'(e.due));
          check($sformatf("u%0d busy_at_done", k), 32'(busy_v[k]), 32'd0);
        end
      end
    end
  end

  task automatic wait_empty(input int k);
    for (int i = 0; i < 40 && sb[k].size() != 0; i++) @(negedge clk);
    if (sb[k].size() != 0) begin
      check($sformatf("u%0d done_timeout", k), 32'(sb[k].size()), 32'd0);
      sb[k].delete();
    end
  endtask

  task automatic run_op(input int k, input logic m, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input logic [7:0] ed, input logic eb, input logic ez);
    exp_t e;
    @(negedge clk);
    mode = m; a = av; b = bv; bin = bi;
    start_v[k] = 1'b1;
    e.diff = ed; e.bout = eb; e.zero = ez; e.due = cyc + 1 + lat(k);
    sb[k].push_back(e);
    @(negedge clk);
    start_v[k] = 1'b0;
    // Scramble inputs mid-run: the latched operands must be unaffected.
    mode = ~m; a = ~av; b = ~bv; bin = ~bi;
    check($sformatf("u%0d busy_in_run", k), 32'(busy_v[k]), 32'd1);
    check($sformatf("u%0d diff_held", k), 32'(diff_v[k]), 32'(last_diff[k]));
    last_diff[k] = ed;
    wait_empty(k);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    exp_t e;
    int   seen;
    int   s;
    logic [7:0] ed;
    logic       eb;

    vecs[0] = '{1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start_v = '0; mode = 1'b0; bin = 1'b0; a = '0; b = '0;
    for (int k = 0; k < 4; k++) last_diff[k] = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d reset_busy", k), 32'(busy_v[k]), 32'd0);
      check($sformatf("u%0d reset_done", k), 32'(done_v[k]), 32'd0);
      check($sformatf("u%0d reset_diff", k), 32'(diff_v[k]), 32'd0);
      check($sformatf("u%0d reset_bout", k), 32'(bout_v[k]), 32'd0);
      check($sformatf("u%0d reset_zero", k), 32'(zero_v[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Table-driven vectors on the bit-serial instance.
    for (int i = 0; i < 8; i++) begin
      run_op(0, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].bi, vecs[i].d, vecs[i].bo, vecs[i].z);
    end

    // start held high across a run with different operands: second op accepted in done cycle.
    @(negedge clk);
    mode = 1'b0; a = 8'h05; b = 8'h03; bin = 1'b0; start_v[0] = 1'b1;
    e = '{8'h02, 1'b0, 1'b0, cyc + 1 + 8};
    sb[0].push_back(e);
    e = '{8'h30, 1'b0, 1'b0, cyc + 1 + 8 + 9};
    sb[0].push_back(e);
    @(negedge clk);
    mode = 1'b1; a = 8'h20; b = 8'h0F; bin = 1'b1;
    repeat (8) @(negedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_empty(0);
    last_diff[0] = 8'h30;

    // Reset three cycles into a run: no done, outputs cleared.
    @(negedge clk);
    mode = 1'b0; a = 8'h44; b = 8'h11; bin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("u0 abort_busy", 32'(busy_v[0]), 32'd0);
    check("u0 abort_done", 32'(done_v[0]), 32'd0);
    check("u0 abort_diff", 32'(diff_v[0]), 32'd0);
    check("u0 abort_bout", 32'(bout_v[0]), 32'd0);
    check("u0 abort_zero", 32'(zero_v[0]), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) seen++;
    end
    check("u0 abort_no_done", 32'(seen), 32'd0);
    for (int k = 0; k < 4; k++) last_diff[k] = '0;
    run_op(0, 1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // Wider slices.
    run_op(1, 1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(1, 1'b1, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);
    run_op(2, 1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op(2, 1'b0, 8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0);

    // Exhaustive 3-bit sweep against an arithmetic model.
    for (int m = 0; m < 2; m++) begin
      for (int ai = 0; ai < 8; ai++) begin
        for (int bi = 0; bi < 8; bi++) begin
          for (int ci = 0; ci < 2; ci++) begin
            if (m == 1) begin
              s  = ai + bi + ci;
              eb = (s > 7);
            end else begin
              s  = ai - bi - ci;
              eb = (ai < bi + ci);
            end
            ed = 8'(s & 7);
            run_op(3, m[0], 8'(ai), 8'(bi), ci[0], ed, eb, ed == 8'h00);
          end
        end
      end
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u%0d pending_left", k), 32'(sb[k].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
